f_reg_file: RTL and testbench

//  Floating-point register file with a scoreboard. Directly feeds read_f_data1/read_f_data2 of
//  the FP ALU and receives its writeback.

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_scoreboard.sv | 32 +++
 rtl/f_reg_file.sv | 39 +++
 tb/tb_f_reg_file.sv | 113 +++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP widths, single-precision field bounds and cop format encodings
package fp_pkg;
  localparam int FP_DATA_W = 64;
  localparam int FP_ADDR_W = 5;
  localparam int FP_NUM_REGS = 32;
  localparam int SINGLE_HI = 63;
  localparam int SINGLE_LO = 32;
  typedef enum logic [4:0] {FMT_S = 5'b10000, FMT_D = 5'b10001} fmt_e;
  // Singles keep the upper word and force the low word to zero so results stay canonical
  function automatic logic [FP_DATA_W-1:0] wb_value(input logic [FP_DATA_W-1:0] d, input logic dbl);
    return dbl ? d : {d[SINGLE_HI:SINGLE_LO], {SINGLE_LO{1'b0}}};
  endfunction
endpackage

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: in-flight destination tracking and RAW/WAW issue stall
module fp_scoreboard
  import fp_pkg::*;
#(
  parameter int NUM_REGS = FP_NUM_REGS,
  parameter int ADDR_W = FP_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                issue_uses_ft,
  input  logic [ADDR_W-1:0]   fs_addr,
  input  logic [ADDR_W-1:0]   ft_addr,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending
);
  logic [NUM_REGS-1:0] pend_q, pend_d, eff_pend;
  // A writeback this cycle retires its register early, and a new issue to it wins over the clear
  always_comb begin
    eff_pend = pend_q & ~(wr_en ? NUM_REGS'(1) << wr_addr : '0);
    stall = issue_valid && (eff_pend[fs_addr] || (issue_uses_ft && eff_pend[ft_addr]) || eff_pend[issue_dest]);
    pend_d = eff_pend | ((issue_valid && !stall) ? NUM_REGS'(1) << issue_dest : '0);
  end
  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else pend_q <= pend_d;
  end
  assign pending = pend_q;
endmodule

// File: rtl/f_reg_file.sv
// f_reg_file: FP register file with write-through bypass and hazard scoreboard
module f_reg_file
  import fp_pkg::*;
#(
  parameter int NUM_REGS = FP_NUM_REGS,
  parameter int ADDR_W = FP_ADDR_W,
  parameter int DATA_W = FP_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   fs_addr,
  input  logic [ADDR_W-1:0]   ft_addr,
  output logic [DATA_W-1:0]   read_f_data1,
  output logic [DATA_W-1:0]   read_f_data2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_double,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                issue_uses_ft,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] wr_val;
  assign wr_val = wb_value(wr_data, wr_double);
  assign read_f_data1 = (wr_en && wr_addr == fs_addr) ? wr_val : regs_q[fs_addr];
  assign read_f_data2 = (wr_en && wr_addr == ft_addr) ? wr_val : regs_q[ft_addr];
  always_ff @(posedge clk) begin
    if (!reset) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (wr_en) regs_q[wr_addr] <= wr_val;
  end
  fp_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_uses_ft(issue_uses_ft),
    .fs_addr(fs_addr), .ft_addr(ft_addr), .stall(stall), .pending(pending)
  );
endmodule

// File: tb/tb_f_reg_file.sv
// tb_f_reg_file: directed and random stimulus against a register/pending model, scoreboard checked
module tb_f_reg_file;
  logic clk = 1'b1;
  logic reset, wr_en, wr_double, issue_valid, issue_uses_ft, stall;
  logic [4:0] fs_addr, ft_addr, wr_addr, issue_dest;
  logic [63:0] wr_data, read_f_data1, read_f_data2;
  logic [31:0] pending;
  typedef struct {
    logic [63:0] r1;
    logic [63:0] r2;
    logic st;
    logic [31:0] pd;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [63:0] m_regs [32];
  bit m_pend [32];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  f_reg_file dut (
    .clk(clk), .reset(reset), .fs_addr(fs_addr), .ft_addr(ft_addr),
    .read_f_data1(read_f_data1), .read_f_data2(read_f_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_double(wr_double),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_uses_ft(issue_uses_ft),
    .stall(stall), .pending(pending)
  );
  function automatic logic [63:0] masked(logic [63:0] d, logic dbl);
    return dbl ? d : {d[63:32], 32'h0};
  endfunction
  function automatic bit busy(int a);
    return m_pend[a] && !(wr_en && int'(wr_addr) == a);
  endfunction
  function automatic bit exp_stall();
    return issue_valid && (busy(int'(fs_addr)) || (issue_uses_ft && busy(int'(ft_addr))) || busy(int'(issue_dest)));
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    vecs++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s got %h want %h at %0t", n, a, x, $time);
    end
  endtask
  task automatic drive(logic rst, logic we, logic [4:0] wa, logic [63:0] wd, logic dbl,
                       logic [4:0] fs, logic [4:0] ft, logic iv, logic [4:0] id, logic uft);
    exp_t x;
    bit st;
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_double = dbl;
    fs_addr = fs; ft_addr = ft; issue_valid = iv; issue_dest = id; issue_uses_ft = uft;
    st = exp_stall();
    if (rst) begin
      x.r1 = (we && wa == fs) ? masked(wd, dbl) : m_regs[fs];
      x.r2 = (we && wa == ft) ? masked(wd, dbl) : m_regs[ft];
      x.st = st;
      for (int i = 0; i < 32; i++) x.pd[i] = m_pend[i];
      q.push_back(x);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    end else begin
      if (we) begin m_regs[wa] = masked(wd, dbl); m_pend[wa] = 0; end
      if (iv && !st) m_pend[id] = 1;
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("read_f_data1", read_f_data1, e.r1);
      chk("read_f_data2", read_f_data2, e.r2);
      chk("stall", {63'h0, stall}, {63'h0, e.st});
      chk("pending", {32'h0, pending}, {32'h0, e.pd});
    end
  end
  initial begin
    int pq[$];
    logic [4:0] wa;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    drive(0, 1, 3, '1, 1, 3, 3, 1, 3, 1);
    drive(0, 1, 3, '1, 1, 3, 3, 1, 3, 1);
    drive(1, 0, 0, 0, 0, 3, 3, 0, 0, 0);
    drive(1, 1, 5, 64'h3F800000_DEADBEEF, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 6, 64'h3FF00000_00000000, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 5, 6, 0, 0, 0);
    drive(1, 1, 7, 64'h40000000_00000000, 1, 7, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 2, 1);
    drive(1, 0, 0, 0, 0, 2, 0, 1, 11, 1);
    drive(1, 1, 2, 64'h12345678_9ABCDEF0, 1, 2, 0, 1, 11, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    drive(1, 1, 4, 64'hC0490FDB_11112222, 1, 0, 0, 1, 4, 1);
    drive(1, 0, 0, 0, 0, 4, 4, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 9, 1);
    drive(1, 0, 0, 0, 0, 1, 9, 1, 10, 0);
    drive(1, 0, 0, 0, 0, 10, 9, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      pq.delete();
      for (int i = 0; i < 32; i++) if (m_pend[i]) pq.push_back(i);
      wa = 5'($urandom_range(0, 7));
      if (pq.size() > 0 && $urandom_range(0, 1)) wa = 5'(pq[$urandom_range(0, pq.size() - 1)]);
      drive(($urandom_range(0, 60) != 0), 1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain got %0d queued want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
